gshare_bht: RTL and testbench

Parametrised global-history branch predictor for the fetch stage: indexes a table of saturating counters by PC XOR a global history register (GHR). It updates the GHR speculatively at prediction time and restores it on a branch-resolution mispredict. After reset it clears its table with an internal sweep. Fetch reads it combinationally; the branch-resolve stage writes it back with the GHR snapshot carried down the pipe.

---
 rtl/gshare_bht_pkg.sv | 27 ++
 rtl/gshare_bht_if.sv | 28 ++
 rtl/gshare_counter_array.sv | 26 ++
 rtl/gshare_bht.sv | 84 ++++++++
 tb/tb_gshare_bht.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/gshare_bht_pkg.sv
// Shared types, default geometry and the saturating counter helper for the gshare predictor.
// Pure declarations: no latency, no flow control.
package gshare_bht_pkg;

  localparam int GS_IDX_BITS = 6;
  localparam int GS_CTR_BITS = 2;
  localparam int GS_GHR_BITS = 6;

  typedef logic [GS_IDX_BITS-1:0] gshare_index_t;
  typedef logic [GS_GHR_BITS-1:0] gshare_ghr_t;

  typedef enum logic {GS_INIT, GS_RUN} gshare_state_t;

  // Counters up to 4 bits are carried in a 4-bit container; callers narrow the result.
  function automatic logic [3:0] sat_update(input logic [3:0] ctr, input logic taken,
                                            input logic [3:0] ctr_max);
    logic [3:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ctr_max) nxt = ctr + 4'd1;
    end else begin
      if (ctr != 4'd0) nxt = ctr - 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_bht_if.sv
// Fetch/resolve side bundle of the gshare predictor; master = pipeline, slave = predictor.
// Prediction path is combinational; ready low means predictions and writes are ignored.
interface gshare_bht_if import gshare_bht_pkg::*; #(
  parameter int GHR_BITS = GS_GHR_BITS
) ();

  logic [15:0]         read_pc;
  logic                read_valid;
  logic                prediction;
  logic [GHR_BITS-1:0] read_ghr;
  logic                ready;
  logic                write;
  logic [15:0]         write_pc;
  logic [GHR_BITS-1:0] write_ghr;
  logic                taken;
  logic                mispredict;

  modport master (
    output read_pc, read_valid, write, write_pc, write_ghr, taken, mispredict,
    input  prediction, read_ghr, ready
  );

  modport slave (
    input  read_pc, read_valid, write, write_pc, write_ghr, taken, mispredict,
    output prediction, read_ghr, ready
  );

endinterface

// File: rtl/gshare_counter_array.sv
// Counter storage: two asynchronous read ports, one synchronous write port.
// Reads are zero-latency; a write lands at the clock edge, so a same-cycle read sees the old value.
module gshare_counter_array #(
  parameter int WIDTH      = 2,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_BITS-1:0] raddr_a_i,
  output logic [WIDTH-1:0]      rdata_a_o,
  input  logic [DEPTH_BITS-1:0] raddr_b_i,
  output logic [WIDTH-1:0]      rdata_b_o
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem[raddr_a_i];
  assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch predictor: PC xor global history indexes saturating counters; history shifts on use.
// Zero-cycle prediction; ready stays low for 2^IDX_BITS cycles after reset while the table is swept.
module gshare_bht import gshare_bht_pkg::*; #(
  parameter int IDX_BITS = GS_IDX_BITS,
  parameter int CTR_BITS = GS_CTR_BITS,
  parameter int GHR_BITS = GS_GHR_BITS
) (
  input  logic          clk,
  input  logic          reset_n,
  gshare_bht_if.slave   bus
);

  localparam logic [CTR_BITS-1:0] INIT_CTR = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [3:0]          CTR_MAX  = 4'((1 << CTR_BITS) - 1);

  gshare_state_t         state_q;
  logic [IDX_BITS-1:0]   sweep_q;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;

  logic [IDX_BITS-1:0]   rd_idx, wr_idx, arr_waddr;
  logic [CTR_BITS-1:0]   rd_ctr, wr_ctr, arr_wdata;
  logic                  arr_we, ready, pred, wr_acc;

  assign ready  = (state_q == GS_RUN);
  assign rd_idx = bus.read_pc[IDX_BITS:1] ^ IDX_BITS'(ghr_q);
  assign wr_idx = bus.write_pc[IDX_BITS:1] ^ IDX_BITS'(bus.write_ghr);
  assign pred   = ready & rd_ctr[CTR_BITS-1];
  assign wr_acc = bus.write & ready;

  // The init sweep owns the single write port until the table is clean.
  assign arr_we    = !ready || wr_acc;
  assign arr_waddr = ready ? wr_idx : sweep_q;
  assign arr_wdata = ready ? CTR_BITS'(sat_update(4'(wr_ctr), bus.taken, CTR_MAX)) : INIT_CTR;

  gshare_counter_array #(
    .WIDTH      (CTR_BITS),
    .DEPTH_BITS (IDX_BITS)
  ) u_arr (
    .clk       (clk),
    .we_i      (arr_we),
    .waddr_i   (arr_waddr),
    .wdata_i   (arr_wdata),
    .raddr_a_i (rd_idx),
    .rdata_a_o (rd_ctr),
    .raddr_b_i (wr_idx),
    .rdata_b_o (wr_ctr)
  );

  // Recovery from the carried snapshot wins over the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (wr_acc && bus.mispredict) begin
      ghr_d = GHR_BITS'({bus.write_ghr, bus.taken});
    end else if (bus.read_valid && ready) begin
      ghr_d = GHR_BITS'({ghr_q, pred});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= GS_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      case (state_q)
        GS_INIT: begin
          sweep_q <= sweep_q + IDX_BITS'(1);
          if (sweep_q == '1) state_q <= GS_RUN;
        end
        default: state_q <= GS_RUN;
      endcase
      ghr_q <= ghr_d;
    end
  end

  assign bus.prediction = pred;
  assign bus.read_ghr   = ghr_q;
  assign bus.ready      = ready;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.read_pc[15:IDX_BITS+1], bus.read_pc[0],
                            bus.write_pc[15:IDX_BITS+1], bus.write_pc[0]};

endmodule

// File: tb/tb_gshare_bht.sv
// Drives a default and a small-geometry predictor with identical stimulus against a reference model.
module tb_gshare_bht;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  gshare_bht_if #(.GHR_BITS(6)) bus0 ();
  gshare_bht_if #(.GHR_BITS(1)) bus1 ();

  gshare_bht #(.IDX_BITS(6), .CTR_BITS(2), .GHR_BITS(6)) dut0 (
    .clk(clk), .reset_n(rst_n), .bus(bus0));
  gshare_bht #(.IDX_BITS(4), .CTR_BITS(3), .GHR_BITS(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Reference state: counter tables, history, cycles left in the clearing sweep.
  int tbl  [2][64];
  int ghr  [2];
  int left [2];

  typedef struct { int tk; int exp_d; int exp_s; } vec_t;
  vec_t vt [21];

  function automatic int ib(int m); return (m == 0) ? 6 : 4; endfunction
  function automatic int cb(int m); return (m == 0) ? 2 : 3; endfunction
  function automatic int gb(int m); return (m == 0) ? 6 : 1; endfunction

  function automatic int m_idx(int m, int pc, int g);
    return ((pc >> 1) & ((1 << ib(m)) - 1)) ^ g;
  endfunction

  function automatic int m_pred(int m, int pc);
    if (left[m] != 0) return 0;
    return (tbl[m][m_idx(m, pc, ghr[m])] >= (1 << (cb(m) - 1))) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rn, input logic [15:0] rpc, input bit rv, input bit wr,
                      input logic [15:0] wpc, input logic [5:0] wg, input bit tk, input bit mp);
    int p, wi, wgm, d, cmax, c;
    rst_n = rn;
    bus0.read_pc = rpc; bus0.read_valid = rv; bus0.write = wr; bus0.write_pc = wpc;
    bus0.write_ghr = wg; bus0.taken = tk; bus0.mispredict = mp;
    bus1.read_pc = rpc; bus1.read_valid = rv; bus1.write = wr; bus1.write_pc = wpc;
    bus1.write_ghr = wg[0]; bus1.taken = tk; bus1.mispredict = mp;
    #1;
    chk("pred0", 32'(bus0.prediction), m_pred(0, int'(rpc)));
    chk("rdy0",  32'(bus0.ready), 32'(left[0] == 0));
    chk("ghr0",  32'(bus0.read_ghr), ghr[0]);
    chk("pred1", 32'(bus1.prediction), m_pred(1, int'(rpc)));
    chk("rdy1",  32'(bus1.ready), 32'(left[1] == 0));
    chk("ghr1",  32'(bus1.read_ghr), ghr[1]);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      d    = 1 << ib(m);
      cmax = (1 << cb(m)) - 1;
      if (!rn) begin
        left[m] = d;
        ghr[m]  = 0;
      end else if (left[m] > 0) begin
        tbl[m][d - left[m]] = (1 << (cb(m) - 1)) - 1;
        left[m]--;
      end else begin
        p   = m_pred(m, int'(rpc));
        wgm = int'(wg) & ((1 << gb(m)) - 1);
        if (wr) begin
          wi = m_idx(m, int'(wpc), wgm);
          c  = tbl[m][wi];
          tbl[m][wi] = tk ? ((c < cmax) ? c + 1 : cmax) : ((c > 0) ? c - 1 : 0);
        end
        if (wr && mp)  ghr[m] = ((wgm << 1) | int'(tk)) & ((1 << gb(m)) - 1);
        else if (rv)   ghr[m] = ((ghr[m] << 1) | p) & ((1 << gb(m)) - 1);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
  endtask

  task automatic check_tables();
    for (int i = 0; i < 64; i++) chk("tbl0", 32'(dut0.u_arr.mem[i]), tbl[0][i]);
    for (int i = 0; i < 16; i++) chk("tbl1", 32'(dut1.u_arr.mem[i]), tbl[1][i]);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) for (int i = 0; i < 64; i++) tbl[m][i] = -1;
    // Saturation walk at pc 0x0010 (entry 8 in both geometries): {taken, 2-bit ctr, 3-bit ctr}.
    vt = '{'{1, 2, 4}, '{1, 3, 5}, '{1, 3, 6}, '{0, 2, 5}, '{0, 1, 4}, '{0, 0, 3}, '{0, 0, 2},
           '{1, 1, 3}, '{1, 2, 4}, '{1, 3, 5}, '{1, 3, 6}, '{1, 3, 7}, '{1, 3, 7},
           '{0, 2, 6}, '{0, 1, 5}, '{0, 0, 4}, '{0, 0, 3}, '{0, 0, 2}, '{0, 0, 1},
           '{0, 0, 0}, '{0, 0, 0}};

    rst_n = 1'b0;
    bus0.read_pc = '0; bus0.read_valid = 1'b0; bus0.write = 1'b0; bus0.write_pc = '0;
    bus0.write_ghr = '0; bus0.taken = 1'b0; bus0.mispredict = 1'b0;
    bus1.read_pc = '0; bus1.read_valid = 1'b0; bus1.write = 1'b0; bus1.write_pc = '0;
    bus1.write_ghr = '0; bus1.taken = 1'b0; bus1.mispredict = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    left[0] = 64; left[1] = 16; ghr[0] = 0; ghr[1] = 0;

    // Initial sweep, with an ignored write/mispredict/read_valid at sweep count 10.
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'($urandom), i == 10, i == 10, 16'h0010, 6'h0, 1'b1, 1'b1);
      chk("init_rdy0", 32'(bus0.ready), 32'(i == 63));
      chk("init_rdy1", 32'(bus1.ready), 32'(i >= 15));
    end
    chk("init_e8", 32'(dut0.u_arr.mem[8]), 1);
    chk("init_s0", 32'(dut1.u_arr.mem[0]), 3);
    check_tables();
    for (int e = 0; e < 64; e++) step(1'b1, 16'(e * 2), 1'b0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      step(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 6'h0, 1'(vt[i].tk), 1'b0);
      chk("sat_d",  32'(dut0.u_arr.mem[8]), vt[i].exp_d);
      chk("sat_s",  32'(dut1.u_arr.mem[8]), vt[i].exp_s);
      chk("sat_pd", 32'(bus0.prediction), 32'(vt[i].exp_d >= 2));
    end

    // Speculative history: entries 8, 9, 11 and 7 trained to weakly taken.
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'h0010, 6'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'h0010, 6'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'h0012, 6'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'h0016, 6'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'h000E, 6'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
      chk("spec_ghr", 32'(bus0.read_ghr), (1 << (k + 1)) - 1);
    end
    bus0.read_pc = 16'h0000; #1;
    chk("spec_idx7", 32'(bus0.prediction), 1);

    // Mispredict recovery beats a same-cycle speculative shift.
    step(1'b1, 16'h0, 1'b0, 1'b1, 16'h0020, 6'b010101, 1'b0, 1'b1);
    chk("mp_ghr_a", 32'(bus0.read_ghr), 32'h2A);
    chk("mp_s_a",   32'(bus1.read_ghr), 0);
    step(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0030, 6'b000011, 1'b0, 1'b1);
    chk("mp_ghr_b", 32'(bus0.read_ghr), 32'h06);
    step(1'b1, 16'h0, 1'b1, 1'b1, 16'h0030, 6'b000000, 1'b1, 1'b1);
    chk("mp_ghr_c", 32'(bus0.read_ghr), 32'h01);
    chk("mp_s_c",   32'(bus1.read_ghr), 1);

    // Reset mid-run, then reset again at sweep count 30; a write at count 10 must be ignored.
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    idle(30);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 6'h0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'($urandom), i == 10, i == 10, 16'h0010, 6'h0, 1'b1, 1'b1);
      chk("mid_rdy0", 32'(bus0.ready), 32'(i == 63));
      chk("mid_rdy1", 32'(bus1.ready), 32'(i >= 15));
    end
    chk("mid_e8",  32'(dut0.u_arr.mem[8]), 1);
    chk("mid_ghr", 32'(bus0.read_ghr), 0);
    check_tables();

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 299) != 0, 16'($urandom_range(0, 255)), 1'($urandom),
           1'($urandom), 16'($urandom_range(0, 255)), 6'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0);
    end
    idle(70);
    check_tables();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
